// File: rtl/spi_slave.sv
// ---------------------------------------------------------------------------
// SpiSlave (module spi_slave)
// SPI mode 0 slave endpoint. It is the far end of the SPI_FSM master and
// oversamples sck, ss_n and mosi on the local system clock.
//
// Frames are DATA_W bits wide and move MSB- or LSB-first. The bit order is
// taken from msb_first when a frame starts and is held until ss_n rises.
// Several bytes may be sent back-to-back while ss_n stays low.
//
// Ports:
//   clk        system clock
//   rstn       synchronous active-low reset
//   sck        SPI clock from the master (asynchronous)
//   ss_n       slave select, active-low (asynchronous)
//   mosi       master-out data (asynchronous)
//   miso       slave-out data
//   msb_first  bit order for the next frame (1 = MSB first)
//   tx_data    byte returned on the next frame, with tx_valid/tx_ready
//   rx_data    last complete received byte
//   rx_valid   one-cycle pulse when rx_data is updated
//   busy       a frame is in progress
//   frame_err  one-cycle pulse when ss_n rises in the middle of a byte
//
// Optional feature, macro SPI_SLAVE_MISO_OE_EN:
//   This macro adds the output miso_oe. It is high while the slave is
//   selected, so the top level can tri-state miso on a shared bus.
//   Without the macro there is no miso_oe port, and miso is driven 0 in IDLE.
//
// Timing limit: the high and low phases of sck must each last at least
// SYNC_STAGES+2 clk cycles.
// ---------------------------------------------------------------------------
module spi_slave #(
   parameter int SYNC_STAGES = 2,
   parameter int DATA_W      = 8
) (
   input  logic              clk,
   input  logic              rstn,
   input  logic              sck,
   input  logic              ss_n,
   input  logic              mosi,
   output logic              miso,
   input  logic              msb_first,
   input  logic [DATA_W-1:0] tx_data,
   input  logic              tx_valid,
   output logic              tx_ready,
   output logic [DATA_W-1:0] rx_data,
   output logic              rx_valid,
   output logic              busy,
`ifdef SPI_SLAVE_MISO_OE_EN
   output logic              miso_oe,
`endif
   output logic              frame_err
);

   localparam int CW = $clog2(DATA_W + 1);
   localparam logic [CW-1:0] CNT_FULL = CW'(DATA_W);
   localparam logic [CW-1:0] CNT_ONE  = CW'(1);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      LOAD  = 2'd1,
      SHIFT = 2'd2
   } state_t;

   logic [SYNC_STAGES-1:0] sckSync_q;
   logic [SYNC_STAGES-1:0] ssSync_q;
   logic [SYNC_STAGES-1:0] mosiSync_q;
   logic                   sckDly_q;
   logic                   sck_s, ss_s, mosi_s;
   logic                   sckRise, sckFall;

   state_t                 state_q, state_d;
   logic                   msb_q, msb_d;
   logic [DATA_W-1:0]      txShift_q, txShift_d;
   logic [DATA_W-1:0]      rxShift_q, rxShift_d;
   logic [CW-1:0]          bitCnt_q, bitCnt_d;
   logic                   miso_q, miso_d;
   logic [DATA_W-1:0]      rxData_q, rxData_d;
   logic                   rxValid_q, rxValid_d;
   logic                   frameErr_q, frameErr_d;
   logic [DATA_W-1:0]      txBuf_q, txBuf_d;
   logic                   txFull_q, txFull_d;
   logic                   load;
   logic [DATA_W-1:0]      loadVal;

   // The synchroniser chains take the asynchronous pins into the clk domain.
   // At reset they hold the idle bus state, which is sck low and ss_n high.
   always_ff @(posedge clk) begin
      if (!rstn) begin
         sckSync_q  <= '0;
         ssSync_q   <= '1;
         mosiSync_q <= '0;
         sckDly_q   <= 1'b0;
      end else begin
         sckSync_q  <= {sckSync_q[SYNC_STAGES-2:0], sck};
         ssSync_q   <= {ssSync_q[SYNC_STAGES-2:0], ss_n};
         mosiSync_q <= {mosiSync_q[SYNC_STAGES-2:0], mosi};
         sckDly_q   <= sck_s;
      end
   end

   assign sck_s   = sckSync_q[SYNC_STAGES-1];
   assign ss_s    = ssSync_q[SYNC_STAGES-1];
   assign mosi_s  = mosiSync_q[SYNC_STAGES-1];
   assign sckRise = sck_s & ~sckDly_q;
   assign sckFall = ~sck_s & sckDly_q;

   // This block holds the state register and all datapath registers.
   always_ff @(posedge clk) begin
      if (!rstn) begin
         state_q    <= IDLE;
         msb_q      <= 1'b1;
         txShift_q  <= '0;
         rxShift_q  <= '0;
         bitCnt_q   <= '0;
         miso_q     <= 1'b0;
         rxData_q   <= '0;
         rxValid_q  <= 1'b0;
         frameErr_q <= 1'b0;
         txBuf_q    <= '0;
         txFull_q   <= 1'b0;
      end else begin
         state_q    <= state_d;
         msb_q      <= msb_d;
         txShift_q  <= txShift_d;
         rxShift_q  <= rxShift_d;
         bitCnt_q   <= bitCnt_d;
         miso_q     <= miso_d;
         rxData_q   <= rxData_d;
         rxValid_q  <= rxValid_d;
         frameErr_q <= frameErr_d;
         txBuf_q    <= txBuf_d;
         txFull_q   <= txFull_d;
      end
   end

   // This block computes the next state and the datapath. A byte is complete
   // once bitCnt_q reaches DATA_W. Completion is handled before an ss_n rise,
   // so a byte that finishes as the slave is deselected is still delivered.
   // After a reload bitCnt_q is 0, and that is how the sck fall that follows
   // the last rise is ignored: shifting on it would drop the first bit of the
   // new byte. An empty transmit buffer loads zeros.
   always_comb begin
      state_d    = state_q;
      msb_d      = msb_q;
      txShift_d  = txShift_q;
      rxShift_d  = rxShift_q;
      bitCnt_d   = bitCnt_q;
      miso_d     = miso_q;
      rxData_d   = rxData_q;
      rxValid_d  = 1'b0;
      frameErr_d = 1'b0;
      txBuf_d    = txBuf_q;
      txFull_d   = txFull_q;
      load       = 1'b0;
      loadVal    = txFull_q ? txBuf_q : '0;

      case (state_q)
         IDLE: begin
            miso_d   = 1'b0;
            bitCnt_d = '0;
            if (!ss_s) begin
               state_d = LOAD;
            end
         end
         LOAD: begin
            load      = 1'b1;
            msb_d     = msb_first;
            txShift_d = loadVal;
            miso_d    = msb_first ? loadVal[DATA_W-1] : loadVal[0];
            bitCnt_d  = '0;
            state_d   = SHIFT;
         end
         SHIFT: begin
            if (bitCnt_q == CNT_FULL) begin
               rxData_d  = rxShift_q;
               rxValid_d = 1'b1;
               bitCnt_d  = '0;
               if (ss_s) begin
                  state_d = IDLE;
                  miso_d  = 1'b0;
               end else begin
                  load      = 1'b1;
                  txShift_d = loadVal;
                  miso_d    = msb_q ? loadVal[DATA_W-1] : loadVal[0];
               end
            end else if (ss_s) begin
               state_d    = IDLE;
               miso_d     = 1'b0;
               bitCnt_d   = '0;
               frameErr_d = (bitCnt_q != '0);
            end else if (sckRise) begin
               rxShift_d = msb_q ? {rxShift_q[DATA_W-2:0], mosi_s}
                                 : {mosi_s, rxShift_q[DATA_W-1:1]};
               bitCnt_d  = bitCnt_q + CNT_ONE;
            end else if (sckFall && (bitCnt_q != '0)) begin
               if (msb_q) begin
                  txShift_d = {txShift_q[DATA_W-2:0], 1'b0};
                  miso_d    = txShift_q[DATA_W-2];
               end else begin
                  txShift_d = {1'b0, txShift_q[DATA_W-1:1]};
                  miso_d    = txShift_q[1];
               end
            end
         end
         default: begin
            state_d = IDLE;
            miso_d  = 1'b0;
         end
      endcase

      // The load empties the buffer. A write in the same cycle is taken only
      // when the buffer was already empty, so its data waits for the next load.
      if (load) begin
         txFull_d = 1'b0;
      end
      if (tx_valid && !txFull_q) begin
         txFull_d = 1'b1;
         txBuf_d  = tx_data;
      end
   end

   assign miso      = miso_q;
   assign tx_ready  = ~txFull_q;
   assign rx_data   = rxData_q;
   assign rx_valid  = rxValid_q;
   assign busy      = (state_q != IDLE);
   assign frame_err = frameErr_q;
`ifdef SPI_SLAVE_MISO_OE_EN
   assign miso_oe   = (state_q != IDLE);
`endif

endmodule

// File: tb/tb_spi_slave.sv
// ---------------------------------------------------------------------------
// Testbench for spi_slave. It runs a mode 0 SPI master at clk/8, with sck
// high and low for 4 clk each.
// Every byte the master sends is queued as an expected receive result. A
// monitor compares the queue against rx_data on each rx_valid pulse.
// The bytes the master reads back on miso are compared in line.
// ---------------------------------------------------------------------------
module tb_spi_slave;

   localparam int DATA_W = 8;

   logic              clk = 1'b0;
   logic              rstn;
   logic              sck;
   logic              ss_n;
   logic              mosi;
   logic              miso;
   logic              msb_first;
   logic [DATA_W-1:0] tx_data;
   logic              tx_valid;
   logic              tx_ready;
   logic [DATA_W-1:0] rx_data;
   logic              rx_valid;
   logic              busy;
   logic              frame_err;
`ifdef SPI_SLAVE_MISO_OE_EN
   logic              miso_oe;
`endif

   int checks        = 0;
   int errors        = 0;
   int rxValidCount  = 0;
   int frameErrCount = 0;
   logic [DATA_W-1:0] rxQ[$];
   logic [DATA_W-1:0] got;
   logic [DATA_W-1:0] got2;
   int savedValid;
   int savedErr;

   spi_slave #(.SYNC_STAGES(2), .DATA_W(DATA_W)) dut (
      .clk       (clk),
      .rstn      (rstn),
      .sck       (sck),
      .ss_n      (ss_n),
      .mosi      (mosi),
      .miso      (miso),
      .msb_first (msb_first),
      .tx_data   (tx_data),
      .tx_valid  (tx_valid),
      .tx_ready  (tx_ready),
      .rx_data   (rx_data),
      .rx_valid  (rx_valid),
      .busy      (busy),
`ifdef SPI_SLAVE_MISO_OE_EN
      .miso_oe   (miso_oe),
`endif
      .frame_err (frame_err)
   );

   // This block drives the system clock with a 10 ns period.
   always #5 clk = ~clk;

   task automatic checkOutput(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
      checks++;
      assert (observed === expected)
      else begin
         errors++;
         $error("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
      end
   endtask

   // The master runs one transfer of nBits bits. mosi changes together with
   // the sck fall. miso is sampled just before each sck rise.
   task automatic applyStimulus(input logic [DATA_W-1:0] txByte, input bit msbOrder,
                                input int nBits, output logic [DATA_W-1:0] rxByte);
      int idx;
      rxByte = '0;
      for (int i = 0; i < nBits; i++) begin
         idx = msbOrder ? (DATA_W - 1 - i) : i;
         mosi = txByte[idx];
         repeat (4) @(negedge clk);
         rxByte[idx] = miso;
         sck = 1'b1;
         repeat (4) @(negedge clk);
         sck = 1'b0;
      end
   endtask

   task automatic writeTx(input logic [DATA_W-1:0] value);
      tx_data  = value;
      tx_valid = 1'b1;
      @(negedge clk);
      tx_valid = 1'b0;
   endtask

   // This monitor is the scoreboard side. On each rx_valid pulse it takes the
   // next expected byte from the queue, and it counts frame_err pulses.
   always @(negedge clk) begin
      logic [DATA_W-1:0] exp;
      if (rstn === 1'b1 && rx_valid === 1'b1) begin
         rxValidCount++;
         if (rxQ.size() == 0) begin
            checkOutput("rx_unexpected", 32'(rx_valid), 32'd0);
         end else begin
            exp = rxQ.pop_front();
            checkOutput("rx_data", 32'(rx_data), 32'(exp));
         end
      end
      if (frame_err === 1'b1) frameErrCount++;
   end

   initial begin
      rstn = 1'b0; sck = 1'b0; ss_n = 1'b1; mosi = 1'b0;
      msb_first = 1'b1; tx_data = '0; tx_valid = 1'b0;

      // Reset is held for 3 clk while sck toggles.
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         sck = ~sck;
      end
      checkOutput("reset_miso", 32'(miso), 32'd0);
      checkOutput("reset_rx_data", 32'(rx_data), 32'd0);
      checkOutput("reset_tx_ready", 32'(tx_ready), 32'd1);
      checkOutput("reset_busy", 32'(busy), 32'd0);
      checkOutput("reset_rx_valid", 32'(rx_valid), 32'd0);
      checkOutput("reset_frame_err", 32'(frame_err), 32'd0);
`ifdef SPI_SLAVE_MISO_OE_EN
      checkOutput("reset_miso_oe", 32'(miso_oe), 32'd0);
`endif
      sck = 1'b0;
      rstn = 1'b1;
      repeat (4) @(negedge clk);

      // Single MSB-first frame: the slave returns A5 while it receives 3C.
      msb_first = 1'b1;
      writeTx(8'hA5);
      checkOutput("tx_ready_after_write", 32'(tx_ready), 32'd0);
      rxQ.push_back(8'h3C);
      ss_n = 1'b0;
      repeat (6) @(negedge clk);
      checkOutput("busy_in_frame", 32'(busy), 32'd1);
`ifdef SPI_SLAVE_MISO_OE_EN
      checkOutput("miso_oe_in_frame", 32'(miso_oe), 32'd1);
`endif
      checkOutput("tx_ready_after_load", 32'(tx_ready), 32'd1);
      applyStimulus(8'h3C, 1'b1, 8, got);
      repeat (4) @(negedge clk);
      ss_n = 1'b1;
      repeat (6) @(negedge clk);
      checkOutput("msb_miso_byte", 32'(got), 32'hA5);
      checkOutput("msb_rx_data", 32'(rx_data), 32'h3C);
      checkOutput("msb_busy_end", 32'(busy), 32'd0);
`ifdef SPI_SLAVE_MISO_OE_EN
      checkOutput("miso_oe_idle", 32'(miso_oe), 32'd0);
`endif
      checkOutput("msb_valid_count", 32'(rxValidCount), 32'd1);

      // LSB-first frame: 81 comes out on miso as the bits 1,0,0,0,0,0,0,1.
      msb_first = 1'b0;
      writeTx(8'h81);
      rxQ.push_back(8'h5A);
      ss_n = 1'b0;
      repeat (6) @(negedge clk);
      msb_first = 1'b1;
      applyStimulus(8'h5A, 1'b0, 8, got);
      repeat (4) @(negedge clk);
      ss_n = 1'b1;
      repeat (6) @(negedge clk);
      checkOutput("lsb_miso_byte", 32'(got), 32'h81);
      checkOutput("lsb_rx_data", 32'(rx_data), 32'h5A);

      // Back-to-back: the first byte is an underrun and returns 00. The C3
      // written after the first load comes back in the second byte.
      msb_first = 1'b1;
      rxQ.push_back(8'h11);
      rxQ.push_back(8'h22);
      ss_n = 1'b0;
      repeat (6) @(negedge clk);
      writeTx(8'hC3);
      applyStimulus(8'h11, 1'b1, 8, got);
      applyStimulus(8'h22, 1'b1, 8, got2);
      repeat (4) @(negedge clk);
      ss_n = 1'b1;
      repeat (6) @(negedge clk);
      checkOutput("b2b_underrun_byte", 32'(got), 32'h00);
      checkOutput("b2b_second_byte", 32'(got2), 32'hC3);
      checkOutput("b2b_valid_count", 32'(rxValidCount), 32'd4);
      checkOutput("b2b_tx_ready", 32'(tx_ready), 32'd1);
      checkOutput("no_frame_err_yet", 32'(frameErrCount), 32'd0);

      // Abort after 5 rises: one frame_err pulse, no rx_valid, rx_data kept.
      savedValid = rxValidCount;
      ss_n = 1'b0;
      repeat (6) @(negedge clk);
      applyStimulus(8'h96, 1'b1, 5, got);
      repeat (2) @(negedge clk);
      ss_n = 1'b1;
      repeat (8) @(negedge clk);
      checkOutput("abort_frame_err", 32'(frameErrCount), 32'd1);
      checkOutput("abort_no_valid", 32'(rxValidCount), 32'(savedValid));
      checkOutput("abort_rx_data", 32'(rx_data), 32'h22);
      checkOutput("abort_busy", 32'(busy), 32'd0);

      // Reset mid-frame: the partial byte is lost with no pulse of any kind.
      savedErr = frameErrCount;
      writeTx(8'h77);
      ss_n = 1'b0;
      repeat (6) @(negedge clk);
      applyStimulus(8'hF0, 1'b1, 3, got);
      rstn = 1'b0;
      ss_n = 1'b1;
      repeat (3) @(negedge clk);
      rstn = 1'b1;
      repeat (6) @(negedge clk);
      checkOutput("rstmid_busy", 32'(busy), 32'd0);
      checkOutput("rstmid_rx_data", 32'(rx_data), 32'd0);
      checkOutput("rstmid_tx_ready", 32'(tx_ready), 32'd1);
      checkOutput("rstmid_frame_err", 32'(frameErrCount), 32'(savedErr));
      checkOutput("rstmid_no_valid", 32'(rxValidCount), 32'(savedValid));
      checkOutput("scoreboard_empty", 32'(rxQ.size()), 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
